apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  CPU-to-APB bridge downstream of the multi-cycle RV32I core's data bus (busAddr/busWData/busRData).
//  Converts one core load/store request into one APB3 transfer (SETUP->ACCESS) and decodes the address
//  to one of NUM_SLAVES peripheral selects (RAM, GPO, GPI, GPIO, ...). Returns read data and a one-cycle
//  ready pulse that the core's control unit uses to advance out of its MEM state.
// PARAMETERS
//  NUM_SLAVES  4             number of PSEL lines / decoded 4 KiB windows
//  BASE_ADDR   32'h1000_0000 base of peripheral region; slave k owns BASE_ADDR + k*0x1000 .. +0xFFF
// PORTS
//  clk       in   1              system clock, all logic rising-edge
//  reset     in   1              asynchronous, active-low reset (0 = reset asserted)
//  transfer  in   1              core request strobe, sampled in IDLE only
//  write     in   1              1 = store, 0 = load
//  addr      in   32             byte address from core (busAddr)
//  wdata     in   32             store data from core (busWData)
//  rdata     out  32             load data to core (busRData)
//  ready     out  1              1-cycle pulse: transfer complete (rdata valid on loads)
//  addr_err  out  1              1-cycle pulse with ready when addr hits no slave window
//  PADDR     out  32             APB address (registered copy of addr)
//  PWRITE    out  1              APB direction
//  PWDATA    out  32             APB write data
//  PENABLE   out  1              APB enable (ACCESS phase)
//  PSEL      out  NUM_SLAVES     one-hot slave select
//  PRDATA    in   NUM_SLAVES*32  slave read data, slave k at [k*32 +: 32]
//  PREADY    in   NUM_SLAVES     slave ready, slave k at bit k
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; PADDR, PWDATA, rdata=0; PWRITE, PENABLE, ready, addr_err=0; PSEL=0.
//  - FSM states IDLE, SETUP, ACCESS.
//    IDLE:   transfer=1 -> latch addr/write/wdata into PADDR/PWRITE/PWDATA, latch decoded select; if select
//            valid -> SETUP, else stay IDLE and pulse ready=1, addr_err=1, rdata=0 next cycle (no APB activity).
//    SETUP:  PSEL=latched one-hot, PENABLE=0; unconditionally -> ACCESS.
//    ACCESS: PSEL held, PENABLE=1; if PREADY[sel]=1 -> capture PRDATA[sel] into rdata (loads only;
//            stores leave rdata unchanged), ready=1 for the next cycle, -> IDLE; else stay (wait states unbounded).
//  - Minimum latency: transfer in cycle N -> SETUP N+1 -> ACCESS N+2 -> ready high in N+3 (zero-wait slave).
//  - ready and addr_err are registered, high for exactly one cycle; PSEL/PENABLE drop the same cycle ready rises.
//  - PADDR/PWRITE/PWDATA stable from SETUP through final ACCESS cycle; unchanged in IDLE (hold last value).
//  - transfer while in SETUP/ACCESS is ignored; core must hold off until ready (no queueing).
//  - transfer asserted in the cycle ready is high is accepted (back-to-back: one IDLE cycle between transfers).
//  - Decode: hit when addr[31:12] - BASE_ADDR[31:12] < NUM_SLAVES; index = that difference; else miss.
//    Only addr_err reports misses; PSEL never asserts for a miss.
//  - PREADY/PRDATA of non-selected slaves are ignored; X on them must not propagate.
//  - Reset mid-transfer: async return to IDLE, all outputs to reset values, no ready pulse afterwards.
// STRUCTURE
//  - Shared package apb_pkg: typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e; localparams
//    APB_SLOT_BITS=12, default BASE_ADDR; used also by the slave-side apb_slave_intf blocks.
//  - One combinational sub-module apb_addr_decoder (addr -> one-hot sel[NUM_SLAVES-1:0], hit); the
//    PRDATA/PREADY selection mux stays inline in the FSM module.
// TESTING
//  - Write 0x1000_1004 <= 0xDEAD_BEEF, PREADY[1] tied 1 -> PSEL=4'b0010, PENABLE 0 then 1, PWDATA=0xDEADBEEF,
//    ready pulses in cycle N+3, addr_err=0.
//  - Read 0x1000_2000, slave 2 PRDATA=0x0000_00A5, PREADY[2] low for 3 ACCESS cycles -> PSEL/PADDR held,
//    ready in N+6, rdata=0x0000_00A5.
//  - Read 0x2000_0000 (unmapped) -> PSEL stays 0, ready=1 and addr_err=1 in N+1, rdata=0.
//  - Back-to-back: write 0x1000_0000 then read 0x1000_3008 re-issued on the ready cycle -> second SETUP one
//    cycle after ready, PSEL=4'b1000, PWRITE=0.
//  - Assert reset=0 during ACCESS with PREADY=0 -> PSEL=0, PENABLE=0, ready=0 immediately; after release
//    no spurious ready; next transfer completes normally.
//  - Transfer pulsed during SETUP/ACCESS with different addr -> ignored, PADDR unchanged, one ready only.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, slot size and default peripheral base.
// Used by the master bridge and the slave-side interface blocks.
package apb_pkg;

    localparam int          APB_SLOT_BITS    = 12;
    localparam logic [31:0] APB_DEFAULT_BASE = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Core-side request/response and APB3 master signals of the bridge.
// The master modport is the bridge view; the slave modport is the core + peripherals view.
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    logic                     transfer;
    logic                     write;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ready;
    logic                     addr_err;

    logic [31:0]              PADDR;
    logic                     PWRITE;
    logic [31:0]              PWDATA;
    logic                     PENABLE;
    logic [NUM_SLAVES-1:0]    PSEL;
    logic [NUM_SLAVES*32-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]    PREADY;

    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY,
        output rdata, ready, addr_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY,
        input  rdata, ready, addr_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto one of NUM_SLAVES consecutive 4 KiB windows above BASE_ADDR.
// Addresses below the base wrap to a large offset and therefore miss.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = APB_DEFAULT_BASE
) (
    input  logic [31:0]           i_addr,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic                  o_hit
);
    localparam int PAGE_W = 32 - APB_SLOT_BITS;

    logic [PAGE_W-1:0] w_page_off;
    logic              w_unused_offset;

    assign w_page_off      = i_addr[31:APB_SLOT_BITS] - BASE_ADDR[31:APB_SLOT_BITS];
    assign o_hit           = (w_page_off < PAGE_W'(NUM_SLAVES));
    assign w_unused_offset = ^i_addr[APB_SLOT_BITS-1:0];

    always_comb begin
        o_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (o_hit && (w_page_off == PAGE_W'(k))) begin
                o_sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Turns one core load/store into one APB3 SETUP->ACCESS transfer and returns a one-cycle ready.
// Unmapped addresses complete immediately with addr_err and never touch the APB bus.
//   state  | meaning
//   IDLE   | waiting for transfer; misses are answered from here
//   SETUP  | PSEL asserted, PENABLE low, one cycle
//   ACCESS | PENABLE high until the selected slave returns PREADY
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = APB_DEFAULT_BASE
) (
    input  logic               clk,
    input  logic               reset,
    apb_master_bridge_if.master bus
);
    apb_state_e            r_state;
    apb_state_e            w_next_state;
    logic [31:0]           r_paddr;
    logic [31:0]           r_pwdata;
    logic [31:0]           r_rdata;
    logic                  r_pwrite;
    logic                  r_ready;
    logic                  r_addr_err;
    logic [NUM_SLAVES-1:0] r_sel;
    logic [NUM_SLAVES-1:0] w_dec_sel;
    logic                  w_dec_hit;
    logic                  w_pready;
    logic [31:0]           w_prdata;
    logic                  w_accept;
    logic                  w_complete;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .i_addr (bus.addr),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    // Gate by the latched select so unselected slaves (possibly X) never reach the result.
    always_comb begin
        w_pready = 1'b0;
        w_prdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_sel[k]) begin
                w_pready = w_pready | bus.PREADY[k];
                w_prdata = w_prdata | bus.PRDATA[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.transfer) begin
                    w_accept = 1'b1;
                    if (w_dec_hit) begin
                        w_next_state = SETUP;
                    end
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (w_pready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pwrite   <= 1'b0;
            r_sel      <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_addr_err <= 1'b0;
            if (w_accept) begin
                r_paddr  <= bus.addr;
                r_pwrite <= bus.write;
                r_pwdata <= bus.wdata;
                r_sel    <= w_dec_sel;
                if (!w_dec_hit) begin
                    r_ready    <= 1'b1;
                    r_addr_err <= 1'b1;
                    r_rdata    <= '0;
                end
            end
            if (w_complete) begin
                r_ready <= 1'b1;
                if (!r_pwrite) begin
                    r_rdata <= w_prdata;
                end
            end
        end
    end

    assign bus.PADDR    = r_paddr;
    assign bus.PWRITE   = r_pwrite;
    assign bus.PWDATA   = r_pwdata;
    assign bus.PSEL     = (r_state != IDLE) ? r_sel : '0;
    assign bus.PENABLE  = (r_state == ACCESS);
    assign bus.rdata    = r_rdata;
    assign bus.ready    = r_ready;
    assign bus.addr_err = r_addr_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of single transfers plus
// hand-written back-to-back, intruding-transfer and mid-transfer reset sequences.
module tb_apb_master_bridge;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          slv;
        int          waits;
        logic [31:0] prdata;
        logic [3:0]  exp_psel;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   slv_wait[4];
    logic [31:0] slv_data[4];
    int   acc_cnt = 0;
    vec_t vecs[8];
    vec_t v_after;

    apb_master_bridge_if #(.NUM_SLAVES(4)) bus ();

    apb_master_bridge #(
        .NUM_SLAVES (4),
        .BASE_ADDR  (32'h1000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: unselected slaves always ready with distinct data; selected slave inserts waits.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) bus.PRDATA[k*32 +: 32] = slv_data[k];
        bus.PREADY = 4'b1111;
        if (bus.PENABLE) begin
            for (int k = 0; k < 4; k++)
                if (bus.PSEL[k]) bus.PREADY[k] = (acc_cnt >= slv_wait[k]);
            acc_cnt = acc_cnt + 1;
        end else begin
            acc_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int   lat;
        int   setup_cnt;
        int   bad_hold;
        logic [3:0] psel_seen;
        bit   done;
        if (v.slv >= 0) begin
            slv_wait[v.slv] = v.waits;
            slv_data[v.slv] = v.prdata;
        end
        @(negedge clk);
        bus.transfer = 1'b1;
        bus.write    = v.wr;
        bus.addr     = v.addr;
        bus.wdata    = v.wdata;
        @(posedge clk);
        #1;
        bus.transfer = 1'b0;
        bus.addr     = ~v.addr;
        bus.wdata    = ~v.wdata;
        lat = 0; setup_cnt = 0; bad_hold = 0; psel_seen = '0; done = 1'b0;
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            @(negedge clk);
            psel_seen = psel_seen | bus.PSEL;
            if (bus.PSEL != 0 && !bus.PENABLE) setup_cnt++;
            if (bus.PSEL != 0 && bus.PADDR !== v.addr) bad_hold++;
            if (bus.ready) begin
                lat  = cyc;
                done = 1'b1;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d psel", idx), 32'(psel_seen), 32'(v.exp_psel));
        check($sformatf("v%0d setup cycles", idx), 32'(setup_cnt), (v.exp_psel != 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d paddr hold", idx), 32'(bad_hold), 32'd0);
        check($sformatf("v%0d addr_err", idx), 32'(bus.addr_err), 32'(v.exp_err));
        check($sformatf("v%0d rdata", idx), bus.rdata, v.exp_rdata);
        check($sformatf("v%0d paddr", idx), bus.PADDR, v.addr);
        check($sformatf("v%0d pwrite", idx), 32'(bus.PWRITE), 32'(v.wr));
        check($sformatf("v%0d pwdata", idx), bus.PWDATA, v.wdata);
        check($sformatf("v%0d psel at ready", idx), 32'(bus.PSEL), 32'd0);
        check($sformatf("v%0d penable at ready", idx), 32'(bus.PENABLE), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d ready pulse", idx), 32'(bus.ready), 32'd0);
        check($sformatf("v%0d addr_err pulse", idx), 32'(bus.addr_err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h1000_1004, 32'hDEAD_BEEF,  1, 0, 32'h0000_0000, 4'b0010, 1'b0, 32'h0000_0000, 3};
        vecs[1] = '{1'b0, 32'h1000_2000, 32'h0000_0000,  2, 3, 32'h0000_00A5, 4'b0100, 1'b0, 32'h0000_00A5, 6};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h0000_0000, -1, 0, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000, 1};
        vecs[3] = '{1'b0, 32'h1000_0FFC, 32'h0000_0000,  0, 1, 32'h1234_5678, 4'b0001, 1'b0, 32'h1234_5678, 4};
        vecs[4] = '{1'b1, 32'h1000_3000, 32'hCAFE_F00D,  3, 0, 32'h0000_0000, 4'b1000, 1'b0, 32'h1234_5678, 3};
        vecs[5] = '{1'b0, 32'h1000_4000, 32'h0000_0000, -1, 0, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000, 1};
        vecs[6] = '{1'b1, 32'h0FFF_FFFC, 32'h0000_7777, -1, 0, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000, 1};
        vecs[7] = '{1'b0, 32'h1000_3FFC, 32'h0000_0000,  3, 2, 32'h8765_4321, 4'b1000, 1'b0, 32'h8765_4321, 5};
        v_after = '{1'b0, 32'h1000_1008, 32'h0000_0000,  1, 0, 32'h0BAD_CAFE, 4'b0010, 1'b0, 32'h0BAD_CAFE, 3};

        for (int k = 0; k < 4; k++) begin
            slv_wait[k] = 0;
            slv_data[k] = 32'hBAD0_0000 + 32'(k);
        end
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.PRDATA   = '0;
        bus.PREADY   = '0;
        reset        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset psel", 32'(bus.PSEL), 32'd0);
        check("reset penable", 32'(bus.PENABLE), 32'd0);
        check("reset ready", 32'(bus.ready), 32'd0);
        check("reset addr_err", 32'(bus.addr_err), 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        check("reset paddr", bus.PADDR, 32'd0);
        check("reset pwdata", bus.PWDATA, 32'd0);
        check("reset pwrite", 32'(bus.PWRITE), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Transfer held high with another address during SETUP and ACCESS must be ignored.
        begin
            int rdy_cnt = 0;
            int rdy_cyc = 0;
            int bad     = 0;
            logic [3:0]  seen = '0;
            logic [31:0] rd   = '0;
            slv_wait[1] = 2;
            slv_data[1] = 32'h1111_2222;
            @(negedge clk);
            bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_1000; bus.wdata = 32'h0;
            @(posedge clk);
            #1;
            bus.write = 1'b1; bus.addr = 32'h1000_2000; bus.wdata = 32'h5A5A_5A5A;
            for (int cyc = 1; cyc <= 10; cyc++) begin
                @(negedge clk);
                if (cyc == 3) begin
                    bus.transfer = 1'b0;
                    bus.write    = 1'b0;
                end
                seen = seen | bus.PSEL;
                if (bus.PSEL != 0 && bus.PADDR !== 32'h1000_1000) bad++;
                if (bus.ready) begin
                    rdy_cnt++;
                    rdy_cyc = cyc;
                    rd      = bus.rdata;
                end
            end
            check("intrude ready count", 32'(rdy_cnt), 32'd1);
            check("intrude ready cycle", 32'(rdy_cyc), 32'd5);
            check("intrude paddr hold", 32'(bad), 32'd0);
            check("intrude psel", 32'(seen), 32'b0010);
            check("intrude rdata", rd, 32'h1111_2222);
            check("intrude paddr final", bus.PADDR, 32'h1000_1000);
            check("intrude pwrite", 32'(bus.PWRITE), 32'd0);
        end

        // Back-to-back: the second request is raised during the first ready cycle.
        begin
            int  rdy1 = 0;
            int  rdy2 = 0;
            bit  issued = 1'b0;
            logic [31:0] rd2 = '0;
            slv_wait[0] = 0;
            slv_wait[3] = 0;
            slv_data[3] = 32'h3333_0008;
            @(negedge clk);
            bus.transfer = 1'b1; bus.write = 1'b1; bus.addr = 32'h1000_0000; bus.wdata = 32'h0000_0042;
            @(posedge clk);
            #1;
            bus.transfer = 1'b0;
            for (int cyc = 1; cyc <= 12 && rdy2 == 0; cyc++) begin
                @(negedge clk);
                if (issued && cyc == rdy1 + 1) begin
                    bus.transfer = 1'b0;
                    check("b2b setup psel", 32'(bus.PSEL), 32'b1000);
                    check("b2b setup penable", 32'(bus.PENABLE), 32'd0);
                    check("b2b setup pwrite", 32'(bus.PWRITE), 32'd0);
                    check("b2b setup paddr", bus.PADDR, 32'h1000_3008);
                end
                if (bus.ready && issued && cyc > rdy1) begin
                    rdy2 = cyc;
                    rd2  = bus.rdata;
                end
                if (bus.ready && !issued) begin
                    issued = 1'b1;
                    rdy1   = cyc;
                    bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_3008; bus.wdata = 32'h0;
                end
            end
            check("b2b first ready cycle", 32'(rdy1), 32'd3);
            check("b2b second ready cycle", 32'(rdy2), 32'd6);
            check("b2b second rdata", rd2, 32'h3333_0008);
        end

        // Reset asserted while the selected slave stalls in ACCESS.
        begin
            bit seen_access = 1'b0;
            int rdy_cnt = 0;
            slv_wait[1] = 1000;
            @(negedge clk);
            bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_1000; bus.wdata = 32'h0;
            @(posedge clk);
            #1;
            bus.transfer = 1'b0;
            for (int c = 0; c < 10 && !seen_access; c++) begin
                @(negedge clk);
                if (bus.PENABLE) seen_access = 1'b1;
            end
            check("rst reached access", 32'(seen_access), 32'd1);
            @(negedge clk);
            #2;
            reset = 1'b0;
            #1;
            check("rst psel", 32'(bus.PSEL), 32'd0);
            check("rst penable", 32'(bus.PENABLE), 32'd0);
            check("rst ready", 32'(bus.ready), 32'd0);
            check("rst paddr", bus.PADDR, 32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (bus.ready) rdy_cnt++;
            end
            check("rst no spurious ready", 32'(rdy_cnt), 32'd0);
            slv_wait[1] = 0;
            run_txn(v_after, 8);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
